// File: rtl/serial_to_parallel_sync_pkg.sv
// Shared symbol-level definitions for the receive deserializer: comma value,
// alignment FSM encoding and counter sizing.
package serial_to_parallel_sync_pkg;

  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] COMMA_SYM = 8'hBC;
  localparam int BC_LOCK_DEF = 4;
  localparam int BC_CNT_W = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_to_parallel_sync.sv
// Serial-to-parallel deserializer: hunts for comma alignment, locks after BC_LOCK
// aligned commas, then emits one symbol per DATA_WIDTH clocks with a per-symbol valid level.
module serial_to_parallel_sync
  import serial_to_parallel_sync_pkg::*;
#(
  parameter int                    DATA_WIDTH = SYM_W,
  parameter logic [DATA_WIDTH-1:0] COMMA      = COMMA_SYM,
  parameter int                    BC_LOCK    = BC_LOCK_DEF
) (
  input  logic                  clk8f,
  input  logic                  reset,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  active
);

  localparam int CNT_W = cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [BC_CNT_W-1:0] LOCK_CNT = BC_CNT_W'(BC_LOCK);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BC_CNT_W-1:0]   bc_cnt_q, bc_cnt_d, bc_inc;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, active_d;

  logic [DATA_WIDTH-1:0] win;
  logic                  is_comma, boundary;

  assign win      = {sr_q[DATA_WIDTH-2:0], data_in};
  assign is_comma = (win == COMMA);
  assign boundary = (bit_cnt_q == LAST_BIT);
  assign bc_inc   = (bc_cnt_q >= LOCK_CNT) ? LOCK_CNT : bc_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_out;
    valid_d   = valid_out;
    active_d  = active;

    case (state_q)
      ALIGN: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == LOCK_CNT) begin
              state_d  = LOCKED;
              active_d = 1'b1;
            end
          end else begin
            // Broken run: search restarts on the next edge's window, not inside this symbol.
            state_d   = HUNT;
            bc_cnt_d  = '0;
            bit_cnt_d = '0;
          end
        end
      end

      LOCKED: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = win;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        // HUNT, and the unused encoding which behaves as HUNT.
        state_d   = HUNT;
        bit_cnt_d = '0;
        bc_cnt_d  = '0;
        if (is_comma) begin
          bc_cnt_d = BC_CNT_W'(1);
          if (LOCK_CNT == BC_CNT_W'(1)) begin
            state_d  = LOCKED;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= win;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
    end
  end

  always_ff @(posedge clk8f or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      data_out  <= data_d;
      valid_out <= valid_d;
      active    <= active_d;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// Directed bench for serial_to_parallel_sync: lock, offset, broken run, idle fill,
// mid-symbol reset, per-edge hold checks and an in-order payload scoreboard.
module tb_serial_to_parallel_sync;

  logic       clk8f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] e_data;
  logic       e_valid;
  logic       e_active;
  logic [7:0] sent_q[$];

  serial_to_parallel_sync dut (
    .clk8f     (clk8f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  always #5 clk8f = ~clk8f;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, " data_out"},  16'(data_out),  16'(e_data));
    check({tag, " valid_out"}, 16'(valid_out), 16'(e_valid));
    check({tag, " active"},    16'(active),    16'(e_active));
  endtask

  // Drive on the falling edge, return #1 after the rising edge that samples it.
  task automatic send_bit(input logic b);
    @(negedge clk8f);
    data_in = b;
    @(posedge clk8f);
    #1;
  endtask

  // Send one symbol MSB first; outputs must hold for the first 7 edges and take the
  // given values on the LSB edge.
  task automatic send_sym(input logic [7:0] sym, input logic nv, input logic [7:0] nd,
                          input logic na, input string tag);
    logic [7:0] exp_sb;
    if (nv) sent_q.push_back(nd);
    for (int i = 7; i >= 1; i--) begin
      send_bit(sym[i]);
      check_outs({tag, " hold"});
    end
    send_bit(sym[0]);
    e_valid  = nv;
    e_data   = nd;
    e_active = na;
    check_outs({tag, " lsb"});
    if (valid_out === 1'b1) begin
      if (sent_q.size() == 0) begin
        check({tag, " sb extra payload"}, 16'(valid_out), 16'h0000);
      end else begin
        exp_sb = sent_q.pop_front();
        check({tag, " sb order"}, 16'(data_out), 16'(exp_sb));
      end
    end
  endtask

  // Four aligned commas from a freshly reset link: active rises on the 4th LSB.
  task automatic lock_run(input string tag);
    for (int i = 0; i < 3; i++) send_sym(8'hBC, 1'b0, e_data, 1'b0, tag);
    send_sym(8'hBC, 1'b0, e_data, 1'b1, tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk8f);
    reset   = 1'b0;
    data_in = 1'b0;
    e_data   = 8'h00;
    e_valid  = 1'b0;
    e_active = 1'b0;
    sent_q.delete();
    #1;
    check_outs(tag);
    @(negedge clk8f);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    data_in  = 1'b0;
    e_data   = 8'h00;
    e_valid  = 1'b0;
    e_active = 1'b0;
    repeat (3) @(negedge clk8f);
    check_outs("por");
    reset = 1'b1;

    // 1: basic lock then payload
    lock_run("t1 lock");
    send_sym(8'h11, 1'b1, 8'h11, 1'b1, "t1 pay11");

    // 2: three junk bits ahead of the comma run
    apply_reset("t2 reset");
    send_bit(1'b1); check_outs("t2 junk");
    send_bit(1'b0); check_outs("t2 junk");
    send_bit(1'b1); check_outs("t2 junk");
    lock_run("t2 lock");
    send_sym(8'hFF, 1'b1, 8'hFF, 1'b1, "t2 payFF");

    // 3: broken comma run, then a full run
    apply_reset("t3 reset");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t3 bc");
    send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t3 bc");
    send_sym(8'h12, 1'b0, 8'h00, 1'b0, "t3 break12");
    lock_run("t3 lock");
    send_sym(8'h13, 1'b1, 8'h13, 1'b1, "t3 pay13");

    // 4: idle comma between payloads
    apply_reset("t4 reset");
    lock_run("t4 lock");
    send_sym(8'h14, 1'b1, 8'h14, 1'b1, "t4 pay14");
    send_sym(8'hBC, 1'b0, 8'h14, 1'b1, "t4 idle");
    send_sym(8'h15, 1'b1, 8'h15, 1'b1, "t4 pay15");

    // 5: asynchronous reset three bits into a symbol
    apply_reset("t5 reset");
    lock_run("t5 lock");
    send_sym(8'hA5, 1'b1, 8'hA5, 1'b1, "t5 payA5");
    send_bit(1'b1); check_outs("t5 fe part");
    send_bit(1'b1); check_outs("t5 fe part");
    send_bit(1'b1); check_outs("t5 fe part");
    #2;
    reset    = 1'b0;
    e_data   = 8'h00;
    e_valid  = 1'b0;
    e_active = 1'b0;
    sent_q.delete();
    #1;
    check_outs("t5 async");
    @(negedge clk8f);
    data_in = 1'b0;
    @(negedge clk8f);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) send_sym(8'hBC, 1'b0, 8'h00, 1'b0, "t5 relock3");
    send_sym(8'h33, 1'b0, 8'h00, 1'b0, "t5 break33");
    lock_run("t5 relock");
    send_sym(8'h44, 1'b1, 8'h44, 1'b1, "t5 pay44");
    send_sym(8'h5A, 1'b1, 8'h5A, 1'b1, "t5 pay5A");

    check("sb drained", 16'(sent_q.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
